// File: rtl/fir_channel_scheduler.sv
// Round-robin scheduler sharing one FIR engine across NUM_CH AXI-Stream channels,
// with one-entry in/out buffers per channel, a job watchdog and sticky error flags.
module fir_channel_scheduler #(
   parameter int NUM_CH  = 4,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                     s_axis_aclk,
   input  logic                     s_axis_arst,
   input  logic [NUM_CH-1:0]        ch_enable,
   input  logic [NUM_CH*DATA_W-1:0] s_axis_tdata,
   input  logic [NUM_CH-1:0]        s_axis_tvalid,
   output logic [NUM_CH-1:0]        s_axis_tready,
   output logic [NUM_CH*DATA_W-1:0] m_axis_tdata,
   output logic [NUM_CH-1:0]        m_axis_tvalid,
   input  logic [NUM_CH-1:0]        m_axis_tready,
   output logic [DATA_W-1:0]        fir_s_tdata,
   output logic                     fir_s_tvalid,
   input  logic                     fir_s_tready,
   output logic [1:0]               fir_s_tuser,
   input  logic [DATA_W-1:0]        fir_m_tdata,
   input  logic                     fir_m_tvalid,
   output logic                     fir_m_tready,
   input  logic [1:0]               fir_m_tuser,
   output logic                     busy,
   output logic                     err_timeout,
   output logic                     err_tuser,
   input  logic                     err_clear
);
   localparam int CH_W = 2;
   localparam int WD_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   state_t              r_state;
   logic [NUM_CH-1:0]   r_in_full;
   logic [NUM_CH-1:0]   r_out_full;
   logic [DATA_W-1:0]   r_in_data  [NUM_CH];
   logic [DATA_W-1:0]   r_out_data [NUM_CH];
   logic [CH_W-1:0]     r_last_grant;
   logic [CH_W-1:0]     r_cur_ch;
   logic [WD_W-1:0]     r_wdog;
   logic [DATA_W-1:0]   r_fir_s_tdata;
   logic [CH_W-1:0]     r_fir_s_tuser;
   logic                r_fir_s_tvalid;
   logic                r_fir_m_tready;
   logic                r_busy;
   logic                r_err_timeout;
   logic                r_err_tuser;

   logic [NUM_CH-1:0]   w_elig;
   logic [NUM_CH-1:0]   w_in_hs;
   logic [NUM_CH-1:0]   w_out_hs;
   logic                w_any;
   logic [CH_W-1:0]     w_grant;
   logic                w_res_hs;
   logic                w_tag_ok;

   // Output space is reserved before granting, so a result is never back-pressured.
   assign w_elig   = r_in_full & ch_enable & ~r_out_full;
   assign w_in_hs  = s_axis_tvalid & ~r_in_full;
   assign w_out_hs = r_out_full & m_axis_tready;
   assign w_res_hs = fir_m_tvalid & r_fir_m_tready;
   assign w_tag_ok = (fir_m_tuser == r_cur_ch);

   always_comb begin
      int unsigned idx;
      idx     = 0;
      w_any   = 1'b0;
      w_grant = '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         idx = (32'(r_last_grant) + 32'd1 + k) % NUM_CH;
         if (!w_any && w_elig[idx]) begin
            w_any   = 1'b1;
            w_grant = CH_W'(idx);
         end
      end
   end

   always_ff @(posedge s_axis_aclk) begin
      if (s_axis_arst) begin
         r_state        <= S_IDLE;
         r_in_full      <= '0;
         r_out_full     <= '0;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            r_in_data[i]  <= '0;
            r_out_data[i] <= '0;
         end
         r_last_grant   <= CH_W'(NUM_CH - 1);
         r_cur_ch       <= '0;
         r_wdog         <= '0;
         r_fir_s_tdata  <= '0;
         r_fir_s_tuser  <= '0;
         r_fir_s_tvalid <= 1'b0;
         r_fir_m_tready <= 1'b0;
         r_busy         <= 1'b0;
         r_err_timeout  <= 1'b0;
         r_err_tuser    <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (w_out_hs[i]) r_out_full[i] <= 1'b0;
            if (w_in_hs[i]) begin
               r_in_full[i] <= 1'b1;
               r_in_data[i] <= s_axis_tdata[i*DATA_W +: DATA_W];
            end
         end

         // Later set assignments below override the clear in the same cycle.
         if (err_clear) begin
            r_err_timeout <= 1'b0;
            r_err_tuser   <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_fir_s_tdata  <= r_in_data[w_grant];
                  r_fir_s_tuser  <= w_grant;
                  r_last_grant   <= w_grant;
                  r_cur_ch       <= w_grant;
                  r_fir_s_tvalid <= 1'b1;
                  r_fir_m_tready <= 1'b1;
                  r_busy         <= 1'b1;
                  r_state        <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (fir_s_tready) begin
                  r_in_full[r_cur_ch] <= 1'b0;
                  r_wdog              <= '0;
                  r_fir_s_tvalid      <= 1'b0;
                  r_state             <= S_WAIT;
               end
               // Any result seen here belongs to an aborted job.
               if (w_res_hs) r_err_tuser <= 1'b1;
            end
            S_WAIT: begin
               if (w_res_hs && w_tag_ok) begin
                  r_out_data[r_cur_ch] <= fir_m_tdata;
                  r_out_full[r_cur_ch] <= 1'b1;
                  r_fir_m_tready       <= 1'b0;
                  r_busy               <= 1'b0;
                  r_state              <= S_IDLE;
               end else if (r_wdog == WD_W'(TIMEOUT)) begin
                  r_err_timeout  <= 1'b1;
                  r_fir_m_tready <= 1'b0;
                  r_busy         <= 1'b0;
                  r_state        <= S_IDLE;
               end else begin
                  r_wdog <= r_wdog + 1'b1;
               end
               if (w_res_hs && !w_tag_ok) r_err_tuser <= 1'b1;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign s_axis_tready = ~r_in_full;
   assign m_axis_tvalid = r_out_full;
   assign fir_s_tdata   = r_fir_s_tdata;
   assign fir_s_tvalid  = r_fir_s_tvalid;
   assign fir_s_tuser   = r_fir_s_tuser;
   assign fir_m_tready  = r_fir_m_tready;
   assign busy          = r_busy;
   assign err_timeout   = r_err_timeout;
   assign err_tuser     = r_err_tuser;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_out
      assign m_axis_tdata[g*DATA_W +: DATA_W] = r_out_data[g];
   end

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Scoreboard bench for fir_channel_scheduler: per-channel sources, a behavioural FIR
// with fixed latency, and a monitor that pops expected results on every output handshake.
module tb_fir_channel_scheduler;
   localparam int NUM_CH  = 4;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 255;
   localparam int FIR_LAT = 130;

   logic         clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic [3:0]   ch_enable;
   logic [127:0] s_tdata;
   logic [3:0]   s_tvalid, s_tready;
   logic [127:0] m_tdata;
   logic [3:0]   m_tvalid, m_tready;
   logic [31:0]  fir_s_tdata;
   logic         fir_s_tvalid, fir_s_tready;
   logic [1:0]   fir_s_tuser;
   logic [31:0]  fir_m_tdata;
   logic         fir_m_tvalid, fir_m_tready;
   logic [1:0]   fir_m_tuser;
   logic         busy, err_timeout, err_tuser, err_clear;

   fir_channel_scheduler #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .s_axis_aclk(clk), .s_axis_arst(rst), .ch_enable(ch_enable),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
      .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
      .fir_s_tdata(fir_s_tdata), .fir_s_tvalid(fir_s_tvalid), .fir_s_tready(fir_s_tready),
      .fir_s_tuser(fir_s_tuser), .fir_m_tdata(fir_m_tdata), .fir_m_tvalid(fir_m_tvalid),
      .fir_m_tready(fir_m_tready), .fir_m_tuser(fir_m_tuser), .busy(busy),
      .err_timeout(err_timeout), .err_tuser(err_tuser), .err_clear(err_clear)
   );

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] src_q [4][$];
   logic [31:0] exp_q [4][$];
   int          grant_q[$];
   int unsigned issue_cyc_q[$];
   logic [31:0] issue_data_q[$];
   int unsigned in_cyc [4];
   int unsigned mv_cyc [4];
   int unsigned res_cyc;

   bit          src_rand, sink_rand, fir_drop, fir_rdy_ctl, inject_req;
   bit [3:0]    sink_hold;
   logic [1:0]  inject_tag;

   int t2_exp [12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
   int t3_exp [10] = '{0, 1, 2, 3, 0, 2, 3, 0, 2, 3};
   int t4_exp [6]  = '{0, 1, 3, 0, 1, 3};

   function automatic logic [31:0] fir_ref(input logic [31:0] d);
      return d * 32'd3 + 32'h11;
   endfunction

   function automatic void chk(input string name, input longint unsigned act, input longint unsigned req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, req);
   endfunction

   function automatic void chk_range(input string name, input longint unsigned act,
                                     input longint unsigned lo, input longint unsigned hi);
      n_checks++;
      if (act >= lo && act <= hi) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
   endfunction

   function automatic bit tb_idle();
      for (int c = 0; c < 4; c++)
         if (src_q[c].size() != 0 || exp_q[c].size() != 0) return 1'b0;
      return !busy && (s_tvalid == 4'b0) && !fir_m_tvalid;
   endfunction

   // Source: one sample per channel presented at a time, held until accepted.
   initial begin
      bit [3:0] pend;
      pend = '0; s_tvalid = '0; s_tdata = '0;
      forever begin
         @(negedge clk);
         for (int c = 0; c < 4; c++) begin
            if (rst) begin
               pend[c] = 1'b0; s_tvalid[c] = 1'b0;
            end else begin
               if (pend[c]) begin
                  exp_q[c].push_back(fir_ref(src_q[c].pop_front()));
                  s_tvalid[c] = 1'b0; pend[c] = 1'b0;
               end
               if (!s_tvalid[c] && src_q[c].size() > 0 && (!src_rand || $urandom_range(2) == 0)) begin
                  s_tvalid[c] = 1'b1;
                  s_tdata[c*32 +: 32] = src_q[c][0];
               end
               pend[c] = s_tvalid[c] & s_tready[c];
               if (pend[c]) in_cyc[c] = cyc;
            end
         end
      end
   end

   // Behavioural FIR: one job at a time, fixed latency, tag echoed back.
   initial begin
      bit in_pend, out_pend, job;
      int cnt;
      logic [31:0] jd;
      logic [1:0]  jt;
      in_pend = 0; out_pend = 0; job = 0; cnt = 0; jd = '0; jt = '0;
      fir_s_tready = 0; fir_m_tvalid = 0; fir_m_tdata = '0; fir_m_tuser = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            in_pend = 0; out_pend = 0; job = 0; fir_m_tvalid = 0; fir_s_tready = 0;
         end else begin
            if (in_pend) begin
               in_pend = 0;
               if (!fir_drop) begin job = 1; cnt = FIR_LAT; end
            end
            if (out_pend) begin out_pend = 0; fir_m_tvalid = 0; end
            if (job) begin
               if (cnt <= 1) begin
                  job = 0; fir_m_tvalid = 1; fir_m_tdata = fir_ref(jd); fir_m_tuser = jt;
               end else cnt--;
            end else if (inject_req && !fir_m_tvalid) begin
               inject_req = 0; fir_m_tvalid = 1; fir_m_tuser = inject_tag; fir_m_tdata = $urandom;
            end
            fir_s_tready = fir_rdy_ctl && !job && !fir_m_tvalid;
            in_pend = fir_s_tvalid && fir_s_tready;
            if (in_pend) begin
               jd = fir_s_tdata; jt = fir_s_tuser;
               grant_q.push_back(int'(fir_s_tuser));
               issue_cyc_q.push_back(cyc);
               issue_data_q.push_back(fir_s_tdata);
            end
            out_pend = fir_m_tvalid && fir_m_tready;
            if (out_pend) res_cyc = cyc;
         end
      end
   end

   // Monitor: every output handshake must match the oldest expected result of its channel.
   initial begin
      bit [3:0] prev_v;
      prev_v = '0; m_tready = '0;
      forever begin
         @(negedge clk);
         for (int c = 0; c < 4; c++) begin
            if (rst) begin
               m_tready[c] = 1'b0; prev_v[c] = 1'b0;
            end else begin
               if (m_tvalid[c] && !prev_v[c]) mv_cyc[c] = cyc;
               prev_v[c] = m_tvalid[c];
               m_tready[c] = sink_hold[c] ? 1'b0 : (sink_rand ? 1'($urandom_range(1)) : 1'b1);
               if (m_tvalid[c] && m_tready[c]) begin
                  if (exp_q[c].size() == 0) begin
                     n_checks++;
                     $display("FAIL unexpected_out_ch%0d: got data %08h, expected no output", c, m_tdata[c*32 +: 32]);
                  end else begin
                     chk($sformatf("out_data_ch%0d", c), m_tdata[c*32 +: 32], exp_q[c].pop_front());
                  end
               end
            end
         end
      end
   end

   task automatic check_reset(input string tag);
      chk({tag, "_s_tready"},     s_tready, 4'hF);
      chk({tag, "_m_tvalid"},     m_tvalid, 4'h0);
      chk({tag, "_m_tdata"},      m_tdata[63:0] | m_tdata[127:64], 0);
      chk({tag, "_fir_s_tvalid"}, fir_s_tvalid, 0);
      chk({tag, "_fir_s_tdata"},  fir_s_tdata, 0);
      chk({tag, "_fir_s_tuser"},  fir_s_tuser, 0);
      chk({tag, "_fir_m_tready"}, fir_m_tready, 0);
      chk({tag, "_busy"},         busy, 0);
      chk({tag, "_err_timeout"},  err_timeout, 0);
      chk({tag, "_err_tuser"},    err_tuser, 0);
   endtask

   task automatic clear_tb();
      for (int c = 0; c < 4; c++) begin
         src_q[c].delete(); exp_q[c].delete();
      end
      grant_q.delete(); issue_cyc_q.delete(); issue_data_q.delete();
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); check_reset(tag); clear_tb();
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic wait_issues(input int n, input int limit, input string name);
      int k = 0;
      while (grant_q.size() < n && k < limit) begin @(negedge clk); k++; end
      if (grant_q.size() < n) begin
         n_checks++;
         $display("FAIL %s: got %0d grants before timeout, expected %0d", name, grant_q.size(), n);
      end
   endtask

   task automatic wait_drain(input int limit, input string name);
      int k = 0;
      while (!tb_idle() && k < limit) begin @(negedge clk); k++; end
      if (!tb_idle()) begin
         n_checks++;
         $display("FAIL %s: got busy=%0d pending outputs at timeout, expected drained", name, busy);
      end
   endtask

   initial begin
      int base, k;
      int unsigned t0, tt;
      rst = 1'b1; ch_enable = 4'hF; err_clear = 1'b0;
      src_rand = 0; sink_rand = 0; sink_hold = '0; fir_drop = 0; fir_rdy_ctl = 1;
      inject_req = 0; inject_tag = '0;
      repeat (3) @(negedge clk);
      check_reset("por");
      clear_tb();
      rst = 1'b0;

      // Single sample on channel 2
      src_q[2].push_back(32'h0000_0100);
      wait_issues(1, 50, "t1_issue");
      if (grant_q.size() >= 1) begin
         chk("t1_fir_tuser", grant_q[0], 2);
         chk("t1_fir_tdata", issue_data_q[0], 32'h100);
         chk("t1_issue_cycle", issue_cyc_q[0], in_cyc[2] + 2);
      end
      wait_drain(1000, "t1_drain");
      chk("t1_out_latency", mv_cyc[2], res_cyc + 1);

      // All channels continuously valid
      do_reset("rst2");
      for (int c = 0; c < 4; c++) for (int j = 0; j < 3; j++) src_q[c].push_back($urandom);
      wait_issues(12, 3000, "t2_issue");
      for (int i = 0; i < 12; i++)
         if (grant_q.size() > i) chk($sformatf("t2_grant%0d", i), grant_q[i], t2_exp[i]);
      wait_drain(1000, "t2_drain");

      // Channel 1 output held
      do_reset("rst3");
      sink_hold = 4'b0010;
      for (int c = 0; c < 4; c++) for (int j = 0; j < 3; j++) src_q[c].push_back($urandom);
      wait_issues(10, 3000, "t3_issue");
      for (int i = 0; i < 10; i++)
         if (grant_q.size() > i) chk($sformatf("t3_grant%0d", i), grant_q[i], t3_exp[i]);
      chk("t3_ch1_held_valid", m_tvalid[1], 1);
      sink_hold = 4'b0000;
      wait_drain(1000, "t3_drain");

      // Channel 2 disabled, then re-enabled
      do_reset("rst4");
      ch_enable = 4'b1011;
      for (int c = 0; c < 4; c++) for (int j = 0; j < 2; j++) src_q[c].push_back($urandom);
      wait_issues(6, 2000, "t4_issue");
      for (int i = 0; i < 6; i++)
         if (grant_q.size() > i) chk($sformatf("t4_grant%0d", i), grant_q[i], t4_exp[i]);
      chk("t4_s_tready2_low", s_tready[2], 0);
      ch_enable = 4'b1111;
      wait_issues(7, 300, "t4_reenable");
      if (grant_q.size() > 6) chk("t4_grant_after_enable", grant_q[6], 2);
      wait_drain(1000, "t4_drain");

      // Watchdog abort, then stale result while in ISSUE
      fir_drop = 1;
      base = grant_q.size();
      src_q[0].push_back($urandom);
      wait_issues(base + 1, 50, "t5_issue");
      t0 = (issue_cyc_q.size() > base) ? issue_cyc_q[base] : cyc;
      k = 0;
      while (!err_timeout && k < 400) begin @(negedge clk); k++; end
      tt = cyc;
      chk("t5_err_timeout", err_timeout, 1);
      chk_range("t5_timeout_delay", tt - t0, TIMEOUT, TIMEOUT + 3);
      chk("t5_idle_after_abort", busy, 0);
      exp_q[0].delete();
      fir_drop = 0;
      fir_rdy_ctl = 0;
      src_q[1].push_back($urandom);
      k = 0;
      while (!fir_s_tvalid && k < 20) begin @(negedge clk); k++; end
      chk("t5_in_issue", fir_s_tvalid, 1);
      inject_tag = 2'd0; inject_req = 1;
      k = 0;
      while (!err_tuser && k < 20) begin @(negedge clk); k++; end
      chk("t5_err_tuser", err_tuser, 1);
      chk("t5_still_busy", busy, 1);
      chk("t5_still_issue_tuser", fir_s_tuser, 1);
      chk("t5_timeout_sticky", err_timeout, 1);
      fir_rdy_ctl = 1;
      wait_drain(1000, "t5_drain");
      @(negedge clk); err_clear = 1'b1;
      @(negedge clk); err_clear = 1'b0;
      chk("t5_clear_timeout", err_timeout, 0);
      chk("t5_clear_tuser", err_tuser, 0);

      // Randomized traffic
      src_rand = 1; sink_rand = 1;
      for (int i = 0; i < 40; i++) begin
         src_q[$urandom_range(3)].push_back($urandom);
         if ($urandom_range(3) == 0) ch_enable = 4'($urandom);
         repeat ($urandom_range(60)) @(negedge clk);
      end
      ch_enable = 4'hF;
      wait_drain(20000, "rand_drain");
      src_rand = 0; sink_rand = 0;

      // Reset in the middle of WAIT
      base = grant_q.size();
      src_q[3].push_back($urandom);
      wait_issues(base + 1, 50, "t7_issue");
      repeat (10) @(negedge clk);
      chk("t7_busy_in_wait", busy, 1);
      do_reset("rst7");
      repeat (200) @(negedge clk);
      chk("t7_quiet_after_reset", m_tvalid, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL global_timeout: got no finish, expected completion");
      $fatal(1, "bench timeout");
   end

endmodule
